// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the memory bus sequencer: widths, FSM encodings and
// processor state codes used alongside the control unit.
package mem_bus_ctrl_pkg;

  localparam int unsigned MBC_ADDR_W = 26;
  localparam int unsigned MBC_DATA_W = 32;
  localparam int unsigned MBC_CNT_W  = 8;

  typedef enum logic [1:0] {
    MBC_IDLE  = 2'd0,
    MBC_REQ   = 2'd1,
    MBC_DONE  = 2'd2,
    MBC_ABORT = 2'd3
  } mbc_state_t;

  typedef enum logic [2:0] {
    PS_FETCH  = 3'd0,
    PS_DECODE = 3'd1,
    PS_EXEC   = 3'd2,
    PS_MEM    = 3'd3,
    PS_WB     = 3'd4
  } proc_state_t;

  // Wait-state counter increments but never wraps back past the timeout.
  function automatic logic [MBC_CNT_W-1:0] sat_inc(input logic [MBC_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Control-unit strobes, memory handshake and result signals of the sequencer.
// master: sequencer view; slave: control unit plus memory model view.
interface mem_bus_ctrl_if
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = MBC_ADDR_W,
  parameter int unsigned DATA_W = MBC_DATA_W
) ();

  logic              READ;
  logic              WRITE;
  logic              IS_FETCH;
  logic [ADDR_W-1:0] ADDR_IN;
  logic [DATA_W-1:0] WDATA_IN;
  logic              MEM_REQ;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              MEM_ACK;
  logic [DATA_W-1:0] RDATA_OUT;
  logic [DATA_W-1:0] INSTRUCTION;
  logic              BUSY;
  logic              ERR;

  modport master (
    input  READ, WRITE, IS_FETCH, ADDR_IN, WDATA_IN, MEM_RDATA, MEM_ACK,
    output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, RDATA_OUT, INSTRUCTION, BUSY, ERR
  );

  modport slave (
    output READ, WRITE, IS_FETCH, ADDR_IN, WDATA_IN, MEM_RDATA, MEM_ACK,
    input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, RDATA_OUT, INSTRUCTION, BUSY, ERR
  );

endinterface

// File: rtl/mbc_edge_det.sv
// Registered rising-edge detector for one level strobe; a level held high
// produces a single-cycle pulse.
module mbc_edge_det (
  input  logic CLK,
  input  logic RST,
  input  logic strobe,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) prev_q <= 1'b0;
    else      prev_q <= strobe;
  end

  assign rise = strobe & ~prev_q;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus sequencer: turns READ/WRITE level strobes into one REQ/ACK
// transaction with a wait-state timeout, capturing load and fetch data.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = MBC_ADDR_W,
  parameter int unsigned DATA_W  = MBC_DATA_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic           CLK,
  input  logic           RST,
  mem_bus_ctrl_if.master bus
);

  localparam logic [MBC_CNT_W:0] TMO = (MBC_CNT_W+1)'(TIMEOUT);

  mbc_state_t           state_q, state_d;
  logic [MBC_CNT_W-1:0] cnt_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q, rdata_q, instr_q;
  logic                 we_q, fetch_q, err_q;
  logic                 rd_rise, wr_rise;
  logic                 start_ok, collide, cnt_hit, in_req;

  mbc_edge_det u_rd_edge (.CLK(CLK), .RST(RST), .strobe(bus.READ),  .rise(rd_rise));
  mbc_edge_det u_wr_edge (.CLK(CLK), .RST(RST), .strobe(bus.WRITE), .rise(wr_rise));

  assign in_req   = (state_q == MBC_REQ);
  assign start_ok = (state_q == MBC_IDLE) && (rd_rise ^ wr_rise);
  assign collide  = (state_q == MBC_IDLE) && rd_rise && wr_rise;
  // True in the REQ cycle whose closing edge brings the count to TIMEOUT.
  assign cnt_hit  = ({1'b0, cnt_q} + 1'b1) >= TMO;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= MBC_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MBC_IDLE:  if (start_ok) state_d = MBC_REQ;
      MBC_REQ: begin
        if (bus.MEM_ACK)  state_d = MBC_DONE;
        else if (cnt_hit) state_d = MBC_ABORT;
      end
      MBC_DONE:  state_d = MBC_IDLE;
      MBC_ABORT: state_d = MBC_IDLE;
      default:   state_d = MBC_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      instr_q <= '0;
      we_q    <= 1'b0;
      fetch_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q  <= bus.ADDR_IN;
        wdata_q <= bus.WDATA_IN;
        we_q    <= bus.WRITE;
        fetch_q <= bus.IS_FETCH;
        err_q   <= 1'b0;
        cnt_q   <= '0;
      end
      if (collide) err_q <= 1'b1;
      if (in_req) begin
        cnt_q <= sat_inc(cnt_q);
        // ACK on the timeout cycle still completes the transaction.
        if (bus.MEM_ACK) begin
          if (!we_q) begin
            rdata_q <= bus.MEM_RDATA;
            if (fetch_q) instr_q <= bus.MEM_RDATA;
          end
        end else if (cnt_hit) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.MEM_REQ     = in_req;
  assign bus.MEM_WE      = in_req & we_q;
  assign bus.MEM_ADDR    = addr_q;
  assign bus.MEM_WDATA   = wdata_q;
  assign bus.RDATA_OUT   = rdata_q;
  assign bus.INSTRUCTION = instr_q;
  assign bus.ERR         = err_q;
  // BUSY rises combinationally in the strobe cycle so the processor stalls at once.
  assign bus.BUSY        = (state_q != MBC_IDLE) | start_ok;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed corner cases plus random
// transactions checked against a transaction-level outcome model.
module tb_mem_bus_ctrl;

  localparam int unsigned AW  = 26;
  localparam int unsigned DW  = 32;
  localparam int          TMO = 15;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  mem_bus_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [DW-1:0] exp_rdata = '0;
  logic [DW-1:0] exp_instr = '0;
  logic          exp_err   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_rdata"}, 64'(bus.RDATA_OUT),   64'(exp_rdata));
    chk({tag, "_instr"}, 64'(bus.INSTRUCTION), 64'(exp_instr));
    chk({tag, "_err"},   64'(bus.ERR),         64'(exp_err));
  endtask

  // From a negedge: drop both strobes and wait until the low level is registered.
  task automatic release_strobes();
    next_cycle();
    bus.READ  = 1'b0;
    bus.WRITE = 1'b0;
    next_cycle();
  endtask

  // Starts at posedge+1 with both strobes low last cycle; ends at a negedge.
  // ack_at = REQ cycle carrying MEM_ACK (0 or > TMO means none arrives).
  task automatic run_txn(input bit is_wr, input bit fetch, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int ack_at,
                         input logic [DW-1:0] rdata);
    bit ok;
    int dur;
    ok  = (ack_at >= 1) && (ack_at <= TMO);
    dur = ok ? ack_at : TMO;
    bus.ADDR_IN  = addr;
    bus.WDATA_IN = wdata;
    bus.IS_FETCH = fetch;
    if (is_wr) bus.WRITE = 1'b1;
    else       bus.READ  = 1'b1;
    @(negedge CLK);
    chk("edge_busy", 64'(bus.BUSY), 64'd1);
    chk("edge_req",  64'(bus.MEM_REQ), 64'd0);
    for (int k = 1; k <= dur; k++) begin
      next_cycle();
      bus.ADDR_IN   = AW'($urandom);
      bus.WDATA_IN  = DW'($urandom);
      bus.IS_FETCH  = 1'($urandom);
      bus.MEM_ACK   = (k == ack_at);
      bus.MEM_RDATA = (k == ack_at) ? rdata : DW'($urandom);
      @(negedge CLK);
      chk("req",      64'(bus.MEM_REQ),   64'd1);
      chk("req_we",   64'(bus.MEM_WE),    64'(is_wr));
      chk("req_addr", 64'(bus.MEM_ADDR),  64'(addr));
      chk("req_wdat", 64'(bus.MEM_WDATA), 64'(wdata));
      chk("req_busy", 64'(bus.BUSY),      64'd1);
      chk("req_err",  64'(bus.ERR),       64'd0);
    end
    next_cycle();
    // A stray ACK after an abort must be ignored.
    bus.MEM_ACK   = !ok;
    bus.MEM_RDATA = DW'($urandom);
    if (ok && !is_wr) begin
      exp_rdata = rdata;
      if (fetch) exp_instr = rdata;
    end
    exp_err = !ok;
    @(negedge CLK);
    chk("end_req",  64'(bus.MEM_REQ), 64'd0);
    chk("end_busy", 64'(bus.BUSY),    64'd1);
    chk_regs("end");
    next_cycle();
    bus.MEM_ACK = 1'b0;
    @(negedge CLK);
    chk("idle_busy", 64'(bus.BUSY),    64'd0);
    chk("idle_req",  64'(bus.MEM_REQ), 64'd0);
    chk_regs("idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit w, f;
    int a;
    bus.READ      = 1'b0;
    bus.WRITE     = 1'b0;
    bus.IS_FETCH  = 1'b0;
    bus.ADDR_IN   = '0;
    bus.WDATA_IN  = '0;
    bus.MEM_RDATA = '0;
    bus.MEM_ACK   = 1'b0;

    // Reset held for two cycles
    @(negedge CLK);
    chk("rst_req",   64'(bus.MEM_REQ),   64'd0);
    chk("rst_we",    64'(bus.MEM_WE),    64'd0);
    chk("rst_addr",  64'(bus.MEM_ADDR),  64'd0);
    chk("rst_wdata", 64'(bus.MEM_WDATA), 64'd0);
    chk("rst_busy",  64'(bus.BUSY),      64'd0);
    chk_regs("rst");
    next_cycle();
    next_cycle();
    RST = 1'b1;
    next_cycle();

    // Zero-wait instruction fetch
    run_txn(1'b0, 1'b1, 26'h0000010, 32'h0, 1, 32'h20220003);
    release_strobes();

    // Store with three wait states
    run_txn(1'b1, 1'b0, 26'h03FFFFF, 32'hDEADBEEF, 4, 32'hA5A5A5A5);
    release_strobes();

    // Read that times out, then a read that clears ERR
    run_txn(1'b0, 1'b0, 26'h0001234, 32'h0, 0, 32'h0);
    release_strobes();
    run_txn(1'b0, 1'b0, 26'h0002000, 32'h0, 3, 32'hCAFEF00D);
    release_strobes();

    // Simultaneous READ and WRITE edges
    bus.READ  = 1'b1;
    bus.WRITE = 1'b1;
    @(negedge CLK);
    chk("coll_busy0", 64'(bus.BUSY),    64'd0);
    chk("coll_req0",  64'(bus.MEM_REQ), 64'd0);
    next_cycle();
    exp_err = 1'b1;
    @(negedge CLK);
    chk("coll_req",  64'(bus.MEM_REQ), 64'd0);
    chk("coll_busy", 64'(bus.BUSY),    64'd0);
    chk_regs("coll");
    release_strobes();

    // READ held high ten cycles: one transaction only
    run_txn(1'b0, 1'b0, 26'h0000ABC, 32'h0, 2, 32'h0BADCAFE);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      @(negedge CLK);
      chk("held_req",  64'(bus.MEM_REQ), 64'd0);
      chk("held_busy", 64'(bus.BUSY),    64'd0);
    end
    release_strobes();

    // Reset in the second REQ wait cycle, then a late ACK
    bus.READ    = 1'b1;
    bus.ADDR_IN = 26'h0000777;
    next_cycle();
    next_cycle();
    @(negedge CLK);
    chk("mid_req_pre", 64'(bus.MEM_REQ), 64'd1);
    #1;
    RST      = 1'b0;
    bus.READ = 1'b0;
    #1;
    exp_rdata = '0;
    exp_instr = '0;
    exp_err   = 1'b0;
    chk("mid_req",  64'(bus.MEM_REQ), 64'd0);
    chk("mid_busy", 64'(bus.BUSY),    64'd0);
    chk_regs("mid");
    next_cycle();
    RST = 1'b1;
    next_cycle();
    bus.MEM_ACK   = 1'b1;
    bus.MEM_RDATA = 32'h55AA55AA;
    next_cycle();
    bus.MEM_ACK = 1'b0;
    @(negedge CLK);
    chk("late_req",  64'(bus.MEM_REQ), 64'd0);
    chk("late_busy", 64'(bus.BUSY),    64'd0);
    chk_regs("late");
    next_cycle();

    // ACK arriving on the timeout cycle wins
    run_txn(1'b0, 1'b0, 26'h0000100, 32'h0, TMO, 32'h12345678);
    release_strobes();

    // Random transactions
    for (int i = 0; i < 12; i++) begin
      w = 1'($urandom);
      f = 1'($urandom);
      a = int'($urandom_range(0, 20));
      run_txn(w, f, AW'($urandom), DW'($urandom), a, DW'($urandom));
      release_strobes();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
